// File: rtl/r4_column_feeder_pkg.sv
// r4_column_feeder shared types and constants.
// Pixel/counter widths and the 9-tall window geometry.
package r4_column_feeder_pkg;
  localparam int PIX_W = 8;
  localparam int CNT_W = 10;
  localparam int R4    = 4;
  localparam int WIN   = 2 * R4 + 1;
  localparam int NBUF  = 2 * R4;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/r4_column_feeder_if.sv
// Pixel stream in, 9-pixel column out.
// master = pixel source / column sink, slave = feeder.
interface r4_column_feeder_if;
  import r4_column_feeder_pkg::*;

  logic valid_i;
  pix_t data_i;
  pix_t S1, S2, S3, S4, S5, S6, S7, S8, S9;
  logic valid_o;
  cnt_t col_o;
  cnt_t row_o;
  logic frame_done_o;

  modport master (
    output valid_i, data_i,
    input  S1, S2, S3, S4, S5, S6, S7, S8, S9,
    input  valid_o, col_o, row_o, frame_done_o
  );

  modport slave (
    input  valid_i, data_i,
    output S1, S2, S3, S4, S5, S6, S7, S8, S9,
    output valid_o, col_o, row_o, frame_done_o
  );
endinterface

// File: rtl/r4_column_feeder_line_buffer.sv
// Enable-advanced delay line of DEPTH pixels.
// Circular pointer into an unreset memory.
module line_buffer
  import r4_column_feeder_pkg::*;
#(
  parameter int DEPTH = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t          mem [DEPTH];
  logic [PW-1:0] ptr;

  // Read-before-write: slot holds the pixel from DEPTH enables ago.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PW'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/r4_column_feeder.sv
// Raster pixel stream to vertical 9-pixel columns.
// Eight cascaded line buffers plus row/col qualification.
module r4_column_feeder
  import r4_column_feeder_pkg::*;
#(
  parameter int COLS = 11,
  parameter int ROWS = 11
) (
  input logic clk,
  input logic rst,
  r4_column_feeder_if.slave bus
);
  localparam bit EN_OUT = (ROWS >= WIN);

  cnt_t col;
  cnt_t row;
  pix_t tap [NBUF+1];
  logic adv;
  logic last_col;
  logic last_row;

  assign adv      = bus.valid_i && !rst;
  assign last_col = (col == cnt_t'(COLS - 1));
  assign last_row = (row == cnt_t'(ROWS - 1));
  assign tap[0]   = bus.data_i;

  for (genvar k = 1; k <= NBUF; k++) begin : g_lb
    line_buffer #(.DEPTH(COLS)) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .din  (tap[k-1]),
      .dout (tap[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_i) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.S1           <= '0;
      bus.S2           <= '0;
      bus.S3           <= '0;
      bus.S4           <= '0;
      bus.S5           <= '0;
      bus.S6           <= '0;
      bus.S7           <= '0;
      bus.S8           <= '0;
      bus.S9           <= '0;
      bus.col_o        <= '0;
      bus.row_o        <= '0;
      bus.valid_o      <= 1'b0;
      bus.frame_done_o <= 1'b0;
    end else if (bus.valid_i) begin
      bus.S9           <= tap[0];
      bus.S8           <= tap[1];
      bus.S7           <= tap[2];
      bus.S6           <= tap[3];
      bus.S5           <= tap[4];
      bus.S4           <= tap[5];
      bus.S3           <= tap[6];
      bus.S2           <= tap[7];
      bus.S1           <= tap[8];
      bus.col_o        <= col;
      bus.row_o        <= row;
      // Stale rows from a prior frame are masked by the row gate alone.
      bus.valid_o      <= EN_OUT && (row >= cnt_t'(NBUF));
      bus.frame_done_o <= EN_OUT && last_row && last_col;
    end else begin
      bus.valid_o      <= 1'b0;
      bus.frame_done_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_r4_column_feeder.sv
// Directed bench for r4_column_feeder.
// Stream pixel = 16*row+col; expectations from a counter model.
module tb_r4_column_feeder;
  localparam int COLS = 11;
  localparam int ROWS = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  r4_column_feeder_if bus ();

  r4_column_feeder #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int mr = 0;
  int mc = 0;
  int nv = 0;
  int nfd = 0;

  logic [7:0] e_s [1:9];
  logic       s_known = 1'b0;
  logic       e_vo = 1'b0;
  logic       e_fd = 1'b0;
  logic [9:0] e_col = '0;
  logic [9:0] e_row = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    logic [7:0] g [1:9];
    g[1] = bus.S1; g[2] = bus.S2; g[3] = bus.S3;
    g[4] = bus.S4; g[5] = bus.S5; g[6] = bus.S6;
    g[7] = bus.S7; g[8] = bus.S8; g[9] = bus.S9;
    if (bus.valid_o === 1'b1) nv++;
    if (bus.frame_done_o === 1'b1) nfd++;
    chk("valid_o", 32'(bus.valid_o), 32'(e_vo));
    chk("frame_done_o", 32'(bus.frame_done_o), 32'(e_fd));
    chk("col_o", 32'(bus.col_o), 32'(e_col));
    chk("row_o", 32'(bus.row_o), 32'(e_row));
    if (s_known) begin
      for (int j = 1; j <= 9; j++) begin
        chk($sformatf("S%0d r%0d c%0d", j, e_row, e_col),
            32'(g[j]), 32'(e_s[j]));
      end
    end
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst = 1'b1;
    bus.valid_i = v;
    bus.data_i = 8'h55;
    @(posedge clk);
    #1;
    mr = 0; mc = 0;
    e_vo = 1'b0; e_fd = 1'b0;
    e_col = '0; e_row = '0;
    for (int j = 1; j <= 9; j++) e_s[j] = '0;
    s_known = 1'b1;
    check_outs();
  endtask

  task automatic push(input logic v);
    @(negedge clk);
    rst = 1'b0;
    bus.valid_i = v;
    bus.data_i = v ? 8'(16 * mr + mc) : 8'hEE;
    @(posedge clk);
    #1;
    if (v) begin
      e_col = 10'(mc);
      e_row = 10'(mr);
      e_vo = (mr >= 8);
      e_fd = (mr == ROWS - 1) && (mc == COLS - 1);
      if (e_vo) begin
        for (int j = 1; j <= 9; j++) e_s[j] = 8'(16 * (mr - 9 + j) + mc);
        s_known = 1'b1;
      end else begin
        s_known = 1'b0;
      end
      mc++;
      if (mc == COLS) begin
        mc = 0;
        mr++;
        if (mr == ROWS) mr = 0;
      end
    end else begin
      e_vo = 1'b0;
      e_fd = 1'b0;
    end
    check_outs();
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    do_reset(1'b1);

    // Frame A: continuous stream.
    nv = 0; nfd = 0;
    repeat (88) push(1'b1);
    chk("A_no_valid_before_row8", 32'(nv), 32'd0);
    push(1'b1);
    chk("A_first_vo", 32'(bus.valid_o), 32'd1);
    chk("A_first_S1", 32'(bus.S1), 32'd0);
    chk("A_first_S5", 32'(bus.S5), 32'd64);
    chk("A_first_S9", 32'(bus.S9), 32'd128);
    chk("A_first_row", 32'(bus.row_o), 32'd8);
    chk("A_first_col", 32'(bus.col_o), 32'd0);
    repeat (31) push(1'b1);
    chk("A_fd_before_last", 32'(nfd), 32'd0);
    push(1'b1);
    chk("A_last_S1", 32'(bus.S1), 32'd42);
    chk("A_last_S9", 32'(bus.S9), 32'd170);
    chk("A_last_row", 32'(bus.row_o), 32'd10);
    chk("A_last_col", 32'(bus.col_o), 32'd10);
    chk("A_last_fd", 32'(bus.frame_done_o), 32'd1);
    chk("A_valid_cols", 32'(nv), 32'd33);

    // Frame B: back to back, no gap.
    nv = 0;
    repeat (88) push(1'b1);
    chk("B_no_stale_valid", 32'(nv), 32'd0);
    push(1'b1);
    chk("B_first_S1", 32'(bus.S1), 32'd0);
    chk("B_first_S9", 32'(bus.S9), 32'd128);
    repeat (32) push(1'b1);
    chk("B_valid_cols", 32'(nv), 32'd33);
    chk("AB_frame_done_pulses", 32'(nfd), 32'd2);

    // Frame C: valid_i toggling 1,0.
    nv = 0; nfd = 0;
    repeat (ROWS * COLS) begin
      push(1'b1);
      push(1'b0);
    end
    chk("C_valid_cols", 32'(nv), 32'd33);
    chk("C_frame_done", 32'(nfd), 32'd1);

    // Mid-frame reset at row 9 col 5 with valid_i high.
    repeat (9 * COLS + 5) push(1'b1);
    chk("R_model_row", 32'(mr), 32'd9);
    do_reset(1'b1);
    nv = 0;
    repeat (88) push(1'b1);
    chk("R_no_valid_88", 32'(nv), 32'd0);
    push(1'b1);
    chk("R_89_vo", 32'(bus.valid_o), 32'd1);
    chk("R_89_row", 32'(bus.row_o), 32'd8);
    chk("R_89_col", 32'(bus.col_o), 32'd0);
    push(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/r4_column_feeder.md
R4_COLUMN_FEEDER -- requirements
Module: r4_column_feeder

Interface
REQ-001 Parameter COLS, default 11: pixels per image row.
REQ-002 Parameter ROWS, default 11: rows per frame.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 valid_i  input  1  data_i carries one raster-order pixel this cycle.
REQ-006 data_i  input  8  unsigned pixel.
REQ-007 S1..S9  output  8 each  vertical 9-pixel column: S1 = row r-8, ..., S9 = row r, all at column c.
REQ-008 valid_o  output  1  S1..S9 hold a complete column this cycle.
REQ-009 col_o  output  10  column index c of the presented column.
REQ-010 row_o  output  10  row index r of the presented column.
REQ-011 frame_done_o  output  1  one-cycle pulse with the last column of a frame.

Function
REQ-012 The block SHALL count input pixels: col counter 0..COLS-1, row counter 0..ROWS-1, both advancing only when valid_i=1.
- col wraps to 0 after COLS-1 and increments row.
- row wraps to 0 after ROWS-1 with col wrap, starting the next frame with no idle cycle.
REQ-013 The block SHALL hold 8 cascaded line buffers, each COLS pixels deep, advancing only when valid_i=1; buffer k outputs the pixel accepted k*COLS valid cycles earlier.
REQ-014 On a valid_i cycle: S9 SHALL be data_i and S(9-k) the output of buffer k (k=1..8), all registered, so outputs appear one cycle after the accepting edge (latency 1).
REQ-015 valid_o SHALL be 1 exactly one cycle after an accepted pixel whose row index >= 8; otherwise 0.
REQ-016 col_o/row_o SHALL be the registered counter values of the accepted pixel, updated with S1..S9.
REQ-017 frame_done_o SHALL be 1 for exactly the cycle valid_o presents row ROWS-1, col COLS-1.
REQ-018 valid_i=0 SHALL freeze counters and buffers; valid_o=0 and frame_done_o=0 the next cycle; S1..S9, col_o, row_o hold their last values.
REQ-019 Valid columns per frame SHALL be (ROWS-8)*COLS, matching the downstream window-sum row count ROWS-8.
REQ-020 Rows from the previous frame SHALL never produce valid_o in a new frame: row gating (REQ-015) alone qualifies output; buffer contents need not be cleared.
REQ-021 ROWS < 9 is unsupported; valid_o SHALL then never assert.

Reset
REQ-022 rst=1 SHALL set col/row counters to 0 and S1..S9, col_o, row_o, valid_o, frame_done_o to 0 on the next edge.
REQ-023 rst SHALL take priority over valid_i; reset mid-frame restarts at row 0 col 0, and no valid_o SHALL assert until 8 full new rows have been accepted.
REQ-024 Line buffer storage SHALL NOT need reset (RAM-inferable).

Structure
REQ-025 Shared package holds pixel width (8), counter width (10) and window radius constant R4 = 4 (window height 2*R4+1 = 9).
REQ-026 One sub-module, line_buffer (parameter DEPTH=COLS, 8-bit, enable-advanced delay line built on a circular pointer into a DEPTH-entry memory), instantiated 8 times in cascade.
REQ-027 Top level contains only counters, cascade, output registers and qualification logic.

Verification
REQ-028 COLS=11, ROWS=11, continuous valid_i, pixel = (16*row+col) mod 256 -> first valid_o one cycle after row 8 col 0 accepted with S1=0, S5=64, S9=128, col_o=0, row_o=8.
REQ-029 Same stream -> exactly 33 valid_o cycles per frame; final one has S1=42, S9=170, row_o=10, col_o=10, frame_done_o=1 that cycle only.
REQ-030 valid_i toggled 1,0,1,0 through the stream -> identical S1..S9 sequence as REQ-028/029 on valid_o cycles; valid_o never high after a valid_i=0 cycle.
REQ-031 Two back-to-back frames, no gap -> second frame first valid_o again at row 8 col 0 with S1=0, S9=128, 33 valid columns, two frame_done_o pulses total.
REQ-032 rst asserted at row 9 col 5 -> all outputs 0 next cycle; 88 subsequent pixels accepted give no valid_o; 89th gives valid_o with row_o=8, col_o=0.
